range_reporter: RTL and testbench
=================================

Name: range_reporter

Overview:
- Downstream consumer of the range-finder stage.
- Captures each completed range result and its error flag, and buffers one pending result.
- Transmits each result as a two-byte UART-style frame on a single serial pin: a status byte, then the range byte.
- Lets the chip report measurements off-die through one uio pin instead of the parallel uo_out bus.

Parameters:
- WIDTH, 8, range input width; legal 1..8; value zero-extended to 8 bits on transmit.
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal >= 2.
- STATUS_OK, 8'hA5, status byte sent when error_in was 0 at capture.
- STATUS_ERR, 8'hEE, status byte sent when error_in was 1 at capture.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- range_in  input  WIDTH  range result from upstream stage.
- error_in  input  1  error flag from upstream stage.
- result_valid  input  1  single-cycle strobe: range_in/error_in are valid this cycle.
- clear_overrun  input  1  synchronous clear of the overrun flag.
- tx  output  1  serial output, idle high.
- busy  output  1  high while a result is held or being transmitted.
- overrun  output  1  sticky: a result was dropped.

Behaviour:
- Reset (rst_n=0 at a rising edge): tx=1, busy=0, overrun=0, hold register empty, FSM=IDLE, all counters 0. Reset mid-frame aborts the frame immediately; tx returns high on that edge.
- Capture: at an edge where result_valid=1 and the hold register is empty, or is being drained on the same edge, store {error_in, zero-extended range_in} and mark hold full.
- Overrun: at an edge where result_valid=1 and the hold register is full and not being drained, drop the new result and set overrun=1.
  - overrun stays set until clear_overrun=1 or reset.
  - If set and clear happen on the same edge, set wins.
- FSM states: IDLE, START, DATA, STOP. A byte index (0=status, 1=range) and a bit counter (0..7) accompany the states.
  - IDLE: if hold is full, drain hold into the shift pair (byte0 = status byte, byte1 = range byte), clear hold, set byte index 0, go to START, drive tx=0 on that edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit 0.
  - DATA: tx = current byte bit[n], LSB first, each bit held CLKS_PER_BIT cycles; after bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - Then if byte index=0: set index 1, go to START with no gap.
    - Otherwise go to IDLE.
    - In IDLE, a pending hold starts the next report on the following edge.
- Baud counter: counts 0..CLKS_PER_BIT-1; the state/bit advances on the terminal count. It is reset to 0 on every state entry.
- Latency and length:
  - Capture at edge E0 → tx falls at edge E1 (if FSM idle).
  - Full report = 20*CLKS_PER_BIT cycles.
  - tx returns to idle after the last stop bit.
- busy = hold full OR FSM != IDLE; registered/derived so it is high from E0+ until the end of the last stop bit.
- Back-to-back: one result may be captured while another is transmitting; a third before the first finishes → overrun.
- range_in/error_in are sampled only on accepted capture edges; changes at other times have no effect.

Test Plan:
- Reset, then idle 50 cycles → tx=1, busy=0, overrun=0 throughout.
- CLKS_PER_BIT=4; pulse result_valid with range_in=8'h3C, error_in=0 → tx falls 1 cycle later.
  - Decoded bytes are 8'hA5 then 8'h3C, LSB-first, with start=0 and stop=1.
  - Total 80 cycles; busy drops after the last stop bit.
- error_in=1, range_in=8'h00 → bytes 8'hEE, 8'h00.
- WIDTH=4, range_in=4'hF → range byte is 8'h0F.
- Pulse valid (8'h11), then valid (8'h22) 10 cycles later → two reports back-to-back (A5 11 A5 22), overrun=0.
  - A third valid (8'h33) while 8'h22 is held → 8'h33 dropped, overrun=1.
  - clear_overrun → overrun=0.
- Assert rst_n=0 during DATA of the second byte → tx=1, busy=0 on that edge.
  - After release, a new valid (8'h7E) transmits a clean A5 7E report.

Source files
------------

// File: rtl/range_reporter.sv
// Buffers one range-finder result and sends it off-die as a two-byte UART frame.
// Ports: clk, rst_n (sync, active-low), range_in/error_in/result_valid in,
//        clear_overrun in, tx/busy/overrun out.
module range_reporter #(
  parameter int          WIDTH        = 8,
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  STATUS_OK    = 8'hA5,
  parameter logic [7:0]  STATUS_ERR   = 8'hEE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] range_in,
  input  logic             error_in,
  input  logic             result_valid,
  input  logic             clear_overrun,
  output logic             tx,
  output logic             busy,
  output logic             overrun
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST =
    CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_e;

  state_e        state_q, state_d;
  logic          hold_full_q, hold_full_d;
  logic          hold_err_q, hold_err_d;
  logic [7:0]    hold_rng_q, hold_rng_d;
  logic [7:0]    byte0_q, byte0_d;
  logic [7:0]    byte1_q, byte1_d;
  logic          idx_q, idx_d;
  logic [2:0]    bit_q, bit_d;
  logic [CW-1:0] baud_q, baud_d;
  logic          tx_q, tx_d;
  logic          ovr_q, ovr_d;

  logic          baud_end;
  logic          drain;
  logic [7:0]    cur_byte;
  logic [2:0]    nxt_bit;

  always_comb begin
    baud_end = (baud_q == BAUD_LAST);
    drain    = (state_q == IDLE) && hold_full_q;
    cur_byte = idx_q ? byte1_q : byte0_q;
    nxt_bit  = bit_q + 3'd1;

    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_err_d  = hold_err_q;
    hold_rng_d  = hold_rng_q;
    byte0_d     = byte0_q;
    byte1_d     = byte1_q;
    idx_d       = idx_q;
    bit_d       = bit_q;
    baud_d      = baud_q + CW'(1);
    tx_d        = tx_q;
    ovr_d       = ovr_q;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (drain) begin
          byte0_d = hold_err_q ? STATUS_ERR : STATUS_OK;
          byte1_d = hold_rng_q;
          idx_d   = 1'b0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          baud_d  = '0;
          tx_d    = cur_byte[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = nxt_bit;
            tx_d  = cur_byte[nxt_bit];
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!idx_q) begin
            // status byte done: range byte follows with no gap
            idx_d   = 1'b1;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // hold register: a drain on this edge frees the slot for a new capture
    if (drain) hold_full_d = 1'b0;
    if (result_valid) begin
      if (!hold_full_q || drain) begin
        hold_full_d = 1'b1;
        hold_err_d  = error_in;
        hold_rng_d  = 8'(range_in);
      end
    end

    // set beats clear when both land on the same edge
    if (result_valid && hold_full_q && !drain)
      ovr_d = 1'b1;
    else if (clear_overrun)
      ovr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_full_q <= 1'b0;
      hold_err_q  <= 1'b0;
      hold_rng_q  <= '0;
      byte0_q     <= '0;
      byte1_q     <= '0;
      idx_q       <= 1'b0;
      bit_q       <= '0;
      baud_q      <= '0;
      tx_q        <= 1'b1;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_err_q  <= hold_err_d;
      hold_rng_q  <= hold_rng_d;
      byte0_q     <= byte0_d;
      byte1_q     <= byte1_d;
      idx_q       <= idx_d;
      bit_q       <= bit_d;
      baud_q      <= baud_d;
      tx_q        <= tx_d;
      ovr_q       <= ovr_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = hold_full_q || (state_q != IDLE);
  assign overrun = ovr_q;

endmodule

// File: tb/tb_range_reporter.sv
// Directed bench for range_reporter: decodes serial reports and
// checks bytes, framing, busy, overrun and reset abort.
module tb_range_reporter;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] range_in;
  logic [3:0] range4;
  logic       error_in;
  logic       result_valid;
  logic       clear_overrun;
  logic       tx, busy, overrun;
  logic       tx4, busy4, overrun4;

  int n_cmp = 0;
  int n_bad = 0;

  logic cap_tx   [0:199];
  logic cap_tx4  [0:199];
  logic cap_busy [0:199];

  always #5 clk = ~clk;

  range_reporter #(
    .WIDTH(8), .CLKS_PER_BIT(C)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .range_in(range_in), .error_in(error_in),
    .result_valid(result_valid),
    .clear_overrun(clear_overrun),
    .tx(tx), .busy(busy), .overrun(overrun)
  );

  range_reporter #(
    .WIDTH(4), .CLKS_PER_BIT(C)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .range_in(range4), .error_in(error_in),
    .result_valid(result_valid),
    .clear_overrun(clear_overrun),
    .tx(tx4), .busy(busy4), .overrun(overrun4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] r,
                       input logic e);
    @(negedge clk);
    range_in     = r;
    error_in     = e;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    range_in     = 8'hFF;
    error_in     = ~e;
  endtask

  // sample k is taken after edge E1+k
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cap_tx[k]   = tx;
      cap_tx4[k]  = tx4;
      cap_busy[k] = busy;
    end
  endtask

  function automatic logic [7:0] dec(input int base,
                                     input bit four);
    logic [7:0] v;
    int idx;
    for (int b = 0; b < 8; b++) begin
      idx  = base + C * (1 + b) + C / 2;
      v[b] = four ? cap_tx4[idx] : cap_tx[idx];
    end
    return v;
  endfunction

  function automatic logic frm(input int base);
    return !cap_tx[base + C / 2] &&
           cap_tx[base + 9 * C + C / 2];
  endfunction

  task automatic chk_report(input string tag,
                            input int base,
                            input logic [7:0] s,
                            input logic [7:0] r);
    chk({tag, "_b0"}, 32'(dec(base, 1'b0)), 32'(s));
    chk({tag, "_b1"}, 32'(dec(base + 10 * C, 1'b0)),
        32'(r));
    chk({tag, "_frm"},
        32'(frm(base) && frm(base + 10 * C)), 32'd1);
    chk({tag, "_busy_last"},
        32'(cap_busy[base + 20 * C - 1]), 32'd1);
  endtask

  initial begin
    int bad;
    rst_n         = 1'b0;
    range_in      = '0;
    range4        = '0;
    error_in      = 1'b0;
    result_valid  = 1'b0;
    clear_overrun = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;

    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 ||
          overrun !== 1'b0) bad++;
    end
    chk("idle50", 32'(bad), 32'd0);

    // basic report, plus the 4-bit instance in parallel
    range4 = 4'hF;
    pulse(8'h3C, 1'b0);
    chk("pre_fall_tx", 32'(tx), 32'd1);
    chk("busy_e0", 32'(busy), 32'd1);
    capture(81);
    chk("fall_lat", 32'(cap_tx[0]), 32'd0);
    chk_report("r3c", 0, 8'hA5, 8'h3C);
    chk("r3c_busy_end", 32'(cap_busy[80]), 32'd0);
    chk("r3c_tx_end", 32'(cap_tx[80]), 32'd1);
    chk("w4_b0", 32'(dec(0, 1'b1)), 32'hA5);
    chk("w4_b1", 32'(dec(10 * C, 1'b1)), 32'h0F);

    // error flag selects the error status byte
    pulse(8'h00, 1'b1);
    capture(81);
    chk_report("rerr", 0, 8'hEE, 8'h00);
    chk("rerr_busy_end", 32'(cap_busy[80]), 32'd0);

    // back-to-back, overrun, set-beats-clear
    pulse(8'h11, 1'b0);
    fork
      capture(161);
      begin
        repeat (8) @(negedge clk);
        pulse(8'h22, 1'b0);
        repeat (10) @(negedge clk);
        chk("ovr_two", 32'(overrun), 32'd0);
        pulse(8'h33, 1'b0);
        chk("ovr_set", 32'(overrun), 32'd1);
        @(negedge clk);
        clear_overrun = 1'b1;
        result_valid  = 1'b1;
        range_in      = 8'h44;
        @(negedge clk);
        clear_overrun = 1'b0;
        result_valid  = 1'b0;
        chk("ovr_set_wins", 32'(overrun), 32'd1);
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);
      end
    join
    chk_report("r11", 0, 8'hA5, 8'h11);
    chk("gap_tx", 32'(cap_tx[80]), 32'd1);
    chk("gap_busy", 32'(cap_busy[80]), 32'd1);
    chk_report("r22", 81, 8'hA5, 8'h22);
    @(negedge clk);
    chk("b2b_busy_end", 32'(busy), 32'd0);

    // reset mid data of range byte (all-zero byte keeps tx low)
    pulse(8'h00, 1'b0);
    repeat (56) @(negedge clk);
    chk("mid_tx_low", 32'(tx), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    pulse(8'h7E, 1'b0);
    capture(81);
    chk_report("r7e", 0, 8'hA5, 8'h7E);
    chk("r7e_busy_end", 32'(cap_busy[80]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
